pc_seq: RTL and testbench

- Parametrised program-counter sequencer; successor to the fixed 32-bit branch-only PC.
- Sits between decode/ALU and instruction memory.
- Adds the following over the previous PC:
  - JAL and JALR targets
  - internal immediate extraction from the raw instruction
  - stall
  - fetch handshake
  - halt/resume FSM
  - misaligned-target trap with configurable reset and trap vectors

---
 rtl/pc_seq.sv | 117 +++++++++++
 tb/tb_pc_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// Program-counter sequencer: BOOT/RUN/HALT fetch control with branch, JAL, JALR and misaligned-target trap.
// Latency: the next pc appears on pc_out one clk after the edge where the fetch fires; pc_plus4 is combinational.
// Backpressure: pc holds while stall=1, fetch_ready=0 or not in RUN; fetch_valid is high only in RUN.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   instr                raw instruction at pc_out (B/J/I immediates extracted here)
//   rs1_val              JALR base operand
//   alu_flag, br_neg     branch condition and its inversion
//   branch, jal, jalr    control-transfer kind of the current instruction
//   stall, fetch_ready   hazard hold / imem accept
//   halt_req, resume     halt/resume control (halt wins when both are set)
//   pc_out, pc_plus4     fetch address and link value
//   fetch_valid, halted  RUN / HALT indication
//   trap, trap_pc        one-cycle misaligned-target pulse and faulting pc
module pc_seq #(
    parameter int                 XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]    TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            alu_flag,
    input  logic            branch,
    input  logic            br_neg,
    input  logic            jal,
    input  logic            jalr,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
    output logic            halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            ctrl_xfer;
    logic            misaligned;
    logic            fire;

    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};

    assign fetch_valid = (state == ST_RUN);
    assign halted      = (state == ST_HALT);
    assign pc_plus4    = pc_out + XLEN'(4);

    assign taken    = branch & (alu_flag ^ br_neg);
    assign fire     = (state == ST_RUN) & fetch_valid & fetch_ready & ~stall;
    assign jalr_sum = rs1_val + imm_i;

    // Priority: jalr, jal, taken branch, sequential.
    always_comb begin
        target = pc_plus4;
        if (jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jal) begin
            target = pc_out + imm_j;
        end else if (taken) begin
            target = pc_out + imm_b;
        end
    end

    // Only a selected control-transfer target can trap; pc+4 keeps alignment.
    assign ctrl_xfer  = jalr | jal | taken;
    assign misaligned = ctrl_xfer & target[1];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  if (halt_req) state_nxt = ST_HALT;
            ST_HALT: if (!halt_req && resume) state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ST_BOOT;
            pc_out  <= RESET_VECTOR;
            trap    <= 1'b0;
            trap_pc <= '0;
        end else begin
            state <= state_nxt;
            trap  <= 1'b0;
            if (fire) begin
                if (misaligned) begin
                    pc_out  <= TRAP_VECTOR;
                    trap    <= 1'b1;
                    trap_pc <= pc_out;
                end else begin
                    pc_out <= target;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Testbench for pc_seq: directed walk through the key control-flow cases plus randomized traffic.
// Latency: outputs checked 1 time unit after each rising edge against a reference model.
// Backpressure: stall/fetch_ready/halt driven by the bench, the model decides whether the pc moves.
module tb_pc_seq;

    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h100;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs1_val = '0;
    logic        alu_flag = 1'b0, branch = 1'b0, br_neg = 1'b0, jal = 1'b0, jalr = 1'b0;
    logic        stall = 1'b0, fetch_ready = 1'b1, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] pc_out, pc_plus4, trap_pc;
    logic        fetch_valid, trap, halted;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_pc, m_tpc;
    logic        m_booting, m_halted, m_trap;

    pc_seq #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .arst_n(arst_n), .instr(instr), .rs1_val(rs1_val),
        .alu_flag(alu_flag), .branch(branch), .br_neg(br_neg), .jal(jal), .jalr(jalr),
        .stall(stall), .fetch_ready(fetch_ready), .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .trap(trap),
        .trap_pc(trap_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Immediates decoded with plain integer arithmetic from the field layout.
    function automatic int dec_b(input logic [31:0] i);
        int v;
        v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (i[31]) v -= 4096;
        return v;
    endfunction

    function automatic int dec_j(input logic [31:0] i);
        int v;
        v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (i[31]) v -= 1048576;
        return v;
    endfunction

    function automatic int dec_i(input logic [31:0] i);
        int v;
        v = int'(i[30:20]);
        if (i[31]) v -= 2048;
        return v;
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] v;
        v = imm[12:0];
        return {v[12], v[10:5], 13'd0, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] v;
        v = imm[20:0];
        return {v[20], v[10:1], v[11], v[19:12], 5'd0, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_i(input int imm);
        logic [11:0] v;
        v = imm[11:0];
        return {v, 13'd0, 7'h67};
    endfunction

    task automatic model_reset();
        m_pc = RV; m_tpc = '0; m_booting = 1'b1; m_halted = 1'b0; m_trap = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc_out, m_pc);
        check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, !m_booting && !m_halted});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
        check({tag, ".trap"}, {31'd0, trap}, {31'd0, m_trap});
        check({tag, ".trap_pc"}, trap_pc, m_tpc);
    endtask

    // One clock: predict from current inputs, take the edge, compare.
    task automatic tick(input string tag);
        logic        running, go, xfer, nb, nh;
        logic [31:0] dest, npc, ntpc;
        running = !m_booting && !m_halted;
        go      = running && fetch_ready && !stall;
        xfer    = 1'b1;
        if (jalr)                             dest = (rs1_val + 32'(dec_i(instr))) & ~32'd1;
        else if (jal)                         dest = m_pc + 32'(dec_j(instr));
        else if (branch && (alu_flag != br_neg)) dest = m_pc + 32'(dec_b(instr));
        else begin dest = m_pc + 32'd4; xfer = 1'b0; end
        npc = m_pc; ntpc = m_tpc;
        if (go) begin
            if (xfer && (dest % 4 >= 2)) begin npc = TV; ntpc = m_pc; end
            else npc = dest;
        end
        nb = 1'b0;
        nh = m_halted;
        if (m_booting)    nh = 1'b0;
        else if (running) nh = halt_req;
        else              nh = halt_req || !resume;
        @(posedge clk);
        #1;
        m_trap    = go && xfer && (dest % 4 >= 2);
        m_pc      = npc;
        m_tpc     = ntpc;
        m_booting = nb;
        m_halted  = nh;
        check_all(tag);
    endtask

    task automatic set_in(input logic [31:0] i, input logic [31:0] r,
                          input logic b, input logic bn, input logic af,
                          input logic j, input logic jr);
        instr = i; rs1_val = r; branch = b; br_neg = bn; alu_flag = af; jal = j; jalr = jr;
    endtask

    task automatic plain();
        set_in(32'h13, 32'd0, 0, 0, 0, 0, 0);
        stall = 0; fetch_ready = 1; halt_req = 0; resume = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check_all("boot");
        check("boot_fv", {31'd0, fetch_valid}, 32'd0);

        plain();
        tick("seq0"); check("seq_pc0", pc_out, 32'h0);
        tick("seq1"); check("seq_pc4", pc_out, 32'h4);
        tick("seq2"); check("seq_pc8", pc_out, 32'h8);
        tick("seq3"); check("seq_pc12", pc_out, 32'hC);

        set_in(enc_j(32'h34), 0, 0, 0, 0, 1, 0); tick("to40");
        set_in(enc_b(-16), 0, 1, 0, 1, 0, 0);    tick("beq"); check("beq_taken", pc_out, 32'h30);
        set_in(enc_j(32'h10), 0, 0, 0, 0, 1, 0); tick("to40b");
        set_in(enc_b(-16), 0, 1, 1, 1, 0, 0);    tick("bne"); check("bne_nt", pc_out, 32'h44);
        set_in(enc_j(32'hBC), 0, 0, 0, 0, 1, 0); tick("to100");
        set_in(enc_j(32'h800), 0, 0, 0, 0, 1, 0); tick("jal"); check("jal_900", pc_out, 32'h900);
        set_in(enc_j(-32'sh800), 0, 0, 0, 0, 1, 0); tick("back100");
        set_in(enc_i(0), 32'h2003, 0, 0, 0, 0, 1); tick("jalr_trap");
        check("trap_pulse", {31'd0, trap}, 32'd1);
        check("trap_vec", pc_out, TV);
        check("trap_pc", trap_pc, 32'h100);
        plain(); tick("trap_end"); check("trap_clr", {31'd0, trap}, 32'd0);

        set_in(enc_i(0), 32'h20, 0, 0, 0, 0, 1); tick("to20");
        plain(); stall = 1;       tick("stall0");
        stall = 0; fetch_ready = 0; tick("stall1");
        stall = 1; fetch_ready = 0; tick("stall2");
        check("stall_hold", pc_out, 32'h20);
        plain(); tick("unstall"); check("unstall_24", pc_out, 32'h24);

        set_in(enc_i(8), 32'h0, 0, 0, 0, 0, 1); tick("to8");
        plain(); halt_req = 1; tick("halt");
        check("halt_pc", pc_out, 32'hC);
        check("halt_flag", {31'd0, halted}, 32'd1);
        halt_req = 0; tick("halt_hold");
        halt_req = 1; resume = 1; tick("halt_wins");
        check("halt_wins", {31'd0, halted}, 32'd1);
        halt_req = 0; resume = 1; tick("resume");
        resume = 0; tick("resume_adv"); check("resume_10", pc_out, 32'h10);

        set_in(enc_i(-4), 32'h0, 0, 0, 0, 0, 1); tick("to_top");
        check("top_pc", pc_out, 32'hFFFF_FFFC);
        plain(); tick("wrap"); check("wrap_0", pc_out, 32'h0);
        check("wrap_notrap", {31'd0, trap}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            instr       = $urandom;
            rs1_val     = $urandom;
            branch      = ($urandom_range(0, 3) == 0);
            br_neg      = $urandom_range(0, 1) != 0;
            alu_flag    = $urandom_range(0, 1) != 0;
            jal         = ($urandom_range(0, 5) == 0);
            jalr        = ($urandom_range(0, 5) == 0);
            stall       = ($urandom_range(0, 4) == 0);
            fetch_ready = ($urandom_range(0, 4) != 0);
            halt_req    = ($urandom_range(0, 15) == 0);
            resume      = ($urandom_range(0, 2) == 0);
            tick("rnd");
        end

        // Reset asserted in the middle of a firing JAL cycle.
        plain(); resume = 1; tick("pre_rst0"); tick("pre_rst1");
        set_in(enc_j(32'h400), 0, 0, 0, 0, 1, 0);
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        check("midrst_pc", pc_out, RV);
        @(negedge clk);
        arst_n = 1'b1;
        plain();
        tick("post_rst0");
        tick("post_rst1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
